// File: rtl/spi_master_mc_if.sv
// Bus-side bundle for spi_master_mc: CPU control/status plus the SPI pins.
// "master" is the controller's view, "slave" is the view of whoever drives it.
interface spi_master_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 2,
    parameter int DIV_WIDTH  = 8,
    parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [CS_W-1:0]       cs_sel;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic                  miso;
    logic                  sclk;
    logic                  mosi;
    logic [NUM_CS-1:0]     cs_n;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  start, tx_data, cs_sel, clk_div, cpol, cpha, lsb_first, miso,
        output sclk, mosi, cs_n, rx_data, busy, done, err
    );

    modport slave (
        output start, tx_data, cs_sel, clk_div, cpol, cpha, lsb_first, miso,
        input  sclk, mosi, cs_n, rx_data, busy, done, err
    );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-mode SPI master: any CPOL/CPHA, MSB/LSB first, N chip selects,
// programmable half-period of clk_div+1 system clocks.
// Timeline per transfer: SETUP (H) -> 2*DATA_WIDTH edge periods (H each,
// first edge at end of SETUP) -> HOLD (H) -> done.
module spi_master_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 2,
    parameter int DIV_WIDTH  = 8,
    parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_mc_if.master  bus
);
    localparam int EW = $clog2(2*DATA_WIDTH+1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_tx_sh, r_rx_sh, r_rx_data;
    logic [NUM_CS-1:0]     r_cs_n, w_cs_dec;
    logic [DIV_WIDTH-1:0]  r_div, r_cnt;
    logic [EW-1:0]         r_ecnt;
    logic                  r_cpol, r_cpha, r_lsb;
    logic                  r_sclk, r_mosi, r_busy, r_done, r_err;
    logic                  w_tick, w_cs_ok, w_accept, w_reject, w_edge, w_finish;
    logic                  w_lead, w_last, w_out_cur, w_out_next;
    logic [DATA_WIDTH-1:0] w_tx_shift, w_rx_shift;

    assign w_tick     = (r_cnt == '0);
    assign w_cs_ok    = (int'(bus.cs_sel) < NUM_CS);
    // Leading edge = sclk currently resting at cpol and about to leave it.
    assign w_lead     = (r_sclk == r_cpol);
    assign w_last     = (r_ecnt == EW'(2*DATA_WIDTH-1));
    assign w_out_cur  = r_lsb ? r_tx_sh[0] : r_tx_sh[DATA_WIDTH-1];
    assign w_out_next = r_lsb ? r_tx_sh[1] : r_tx_sh[DATA_WIDTH-2];
    assign w_tx_shift = r_lsb ? {1'b0, r_tx_sh[DATA_WIDTH-1:1]}
                              : {r_tx_sh[DATA_WIDTH-2:0], 1'b0};
    assign w_rx_shift = r_lsb ? {bus.miso, r_rx_sh[DATA_WIDTH-1:1]}
                              : {r_rx_sh[DATA_WIDTH-2:0], bus.miso};

    // Decode requested chip select into an active-low one-cold mask.
    always_comb begin
        w_cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(bus.cs_sel) == i) w_cs_dec[i] = 1'b0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-cycle event strobes.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        w_edge   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: if (bus.start) begin
                if (w_cs_ok) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end else begin
                    w_reject = 1'b1;
                end
            end
            SETUP: if (w_tick) begin
                w_edge = 1'b1;
                w_next = XFER;
            end
            // After the last edge the period still runs out before HOLD.
            XFER: if (w_tick) begin
                if (r_ecnt == EW'(2*DATA_WIDTH)) w_next = HOLD;
                else                             w_edge = 1'b1;
            end
            HOLD: if (w_tick) begin
                w_finish = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: latch config, half-period counter, sclk/shift/sample, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_cs_n    <= '1;
            r_div     <= '0;
            r_cnt     <= '0;
            r_ecnt    <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsb     <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            if (r_state == IDLE) r_sclk <= bus.cpol;
            if (w_accept) begin
                r_tx_sh <= bus.tx_data;
                r_rx_sh <= '0;
                r_div   <= bus.clk_div;
                r_cnt   <= bus.clk_div;
                r_ecnt  <= '0;
                r_cpol  <= bus.cpol;
                r_cpha  <= bus.cpha;
                r_lsb   <= bus.lsb_first;
                r_busy  <= 1'b1;
                r_cs_n  <= w_cs_dec;
                // cpha=0 presents the first bit before the first edge.
                r_mosi  <= bus.cpha ? 1'b0
                         : (bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_WIDTH-1]);
            end else if (r_state != IDLE) begin
                r_cnt <= w_tick ? r_div : r_cnt - 1'b1;
            end
            if (w_edge) begin
                r_sclk <= ~r_sclk;
                r_ecnt <= r_ecnt + 1'b1;
                if (w_lead != r_cpha) r_rx_sh <= w_rx_shift;
                if (r_cpha ? w_lead : (!w_lead && !w_last)) begin
                    r_tx_sh <= w_tx_shift;
                    r_mosi  <= r_cpha ? w_out_cur : w_out_next;
                end
            end
            if (w_finish) begin
                r_sclk    <= r_cpol;
                r_cs_n    <= '1;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_rx_data <= r_rx_sh;
            end
        end
    end

    assign bus.sclk    = r_sclk;
    assign bus.mosi    = r_mosi;
    assign bus.cs_n    = r_cs_n;
    assign bus.rx_data = r_rx_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: MSB-first slave model on the pins, scoreboard of
// expected rx_data / slave capture / busy length checked at each done pulse.
module tb_spi_master_mc;
    localparam int DW = 8, NCS = 2, DIVW = 8, CSW = 2;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] slv;
        int         cyc;
        logic [1:0] csn;
        logic       mosi0;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_mc_if #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW), .CS_W(CSW)) bus ();
    spi_master_mc #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW), .CS_W(CSW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int   n_chk = 0, n_fail = 0;
    int   busy_cnt = 0, n_done = 0, n_err = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic       t_cpol = 1'b0, t_cpha = 1'b0, loopback = 1'b0;
    logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
    logic       s_miso = 1'b0, sclk_p = 1'b0;
    logic [1:0] csn_p = 2'b11;
    int         s_idx = 0;

    assign bus.miso = loopback ? bus.mosi : s_miso;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Slave: MSB-first, samples on rising edge iff cpol==cpha, shifts on the other edge.
    always @(negedge clk) begin
        if (bus.cs_n != 2'b11 && csn_p == 2'b11) begin
            s_rx = 8'h00;
            if (!t_cpha) begin s_miso = s_tx[7]; s_idx = 6; end
            else         s_idx = 7;
        end else if (bus.cs_n != 2'b11 && bus.sclk != sclk_p) begin
            if (bus.sclk == (t_cpol == t_cpha)) s_rx = {s_rx[6:0], bus.mosi};
            else if (s_idx >= 0) begin s_miso = s_tx[s_idx]; s_idx--; end
        end
        sclk_p = bus.sclk;
        csn_p  = bus.cs_n;
    end

    // Monitor: first-cycle checks, busy length, scoreboard pop on done.
    always @(negedge clk) begin
        if (bus.err) n_err++;
        if (bus.busy) begin
            busy_cnt++;
            if (busy_cnt == 1 && sb.size() > 0) begin
                chk("cs_n_active", bus.cs_n, sb[0].csn);
                chk("mosi_first", bus.mosi, sb[0].mosi0);
            end
        end
        if (bus.done) begin
            n_done++;
            chk("sb_nonempty", sb.size(), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("rx_data", bus.rx_data, mon_e.rx);
                chk("slave_rx", s_rx, mon_e.slv);
                chk("busy_cycles", busy_cnt, mon_e.cyc);
                chk("cs_n_done", bus.cs_n, 2'b11);
            end
        end
        if (!bus.busy) busy_cnt = 0;
    end

    task automatic xfer(input logic [7:0] tx, input logic [1:0] cs, input logic [7:0] div,
                        input logic pol, input logic pha, input logic lsb,
                        input logic loop, input logic [7:0] stx);
        exp_t e;
        @(negedge clk);
        t_cpol = pol; t_cpha = pha; loopback = loop; s_tx = stx;
        bus.cpol = pol; bus.cpha = pha; bus.lsb_first = lsb;
        bus.clk_div = div; bus.cs_sel = cs; bus.tx_data = tx;
        @(negedge clk);
        @(negedge clk);
        chk("sclk_idle", bus.sclk, pol);
        e.rx    = loop ? tx : (lsb ? rev8(stx) : stx);
        e.slv   = lsb ? rev8(tx) : tx;
        e.cyc   = (2*DW+2) * (int'(div) + 1);
        e.csn   = ~(2'b01 << cs);
        e.mosi0 = pha ? 1'b0 : (lsb ? tx[0] : tx[7]);
        sb.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n0 = n_done;
        int k  = 0;
        while (n_done == n0 && k < limit) begin @(negedge clk); k++; end
        chk("done_timeout", (n_done > n0), 1);
    endtask

    int nd0, ne0;

    initial begin
        bus.start = 1'b0; bus.tx_data = '0; bus.cs_sel = '0; bus.clk_div = '0;
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", bus.cs_n, 2'b11);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rx", bus.rx_data, 0);
        rst = 1'b0;

        // mode 0, loopback
        xfer(8'hA5, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        wait_done(200);
        // mode 3, divided clock, cs 1
        xfer(8'hC3, 2'd1, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        wait_done(400);
        // LSB first
        xfer(8'h01, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h35);
        wait_done(200);

        // mode 1 with a second start mid-transfer
        nd0 = n_done; ne0 = n_err;
        xfer(8'h5A, 2'd1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h96);
        repeat (10) @(negedge clk);
        bus.tx_data = 8'hFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(400);
        repeat (20) @(negedge clk);
        chk("single_done", n_done - nd0, 1);
        chk("no_err_busy", n_err - ne0, 0);

        // out-of-range chip select
        bus.cs_sel = 2'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("err_pulse", bus.err, 1);
        chk("err_busy", bus.busy, 0);
        chk("err_cs_n", bus.cs_n, 2'b11);
        @(negedge clk);
        chk("err_clear", bus.err, 0);
        chk("err_cs_n2", bus.cs_n, 2'b11);

        // reset abort mid-transfer (mode 2 so sclk=0 differs from idle)
        xfer(8'h69, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cs_n", bus.cs_n, 2'b11);
        chk("abort_sclk", bus.sclk, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_rx", bus.rx_data, 0);
        xfer(8'h96, 2'd1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        wait_done(400);
        repeat (5) @(negedge clk);

        chk("err_total", n_err, 1);
        chk("done_total", n_done, 5);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
